fwd_scoreboard: RTL and testbench

- Parametrised successor to the per-operand forwarding muxes: one block that tracks in-flight register writes and resolves every ID-stage read port.
- Keeps a shift-register scoreboard of destination tags and availability stages for each pipeline slot after ID.
- Per read port, it selects register-file data or a pipeline-slot result, or raises a load-use/late-result stall.
- Sits between ID and the datapath. It replaces fixed EX/MEM/WB priority chains with generic youngest-match logic, and adds a stall performance counter.

---
 rtl/fwd_scoreboard.sv | 112 +++++++++++
 tb/tb_fwd_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight register writes per pipeline slot after ID
// and resolves every ID read port to register-file data, a slot result, or a stall.
module fwd_scoreboard #(
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int W     = 32,
    parameter int AW    = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_dst,
    input  logic [AW-1:0]        issue_avail,
    input  logic                 flush,
    input  logic [NREAD*5-1:0]   rd_reg,
    input  logic [NREAD*W-1:0]   rd_data,
    input  logic [DEPTH*W-1:0]   stage_data,
    output logic [NREAD*W-1:0]   fwd_data,
    output logic [NREAD*AW-1:0]  fwd_src,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_count
);

    logic             v_q     [1:DEPTH];
    logic             v_d     [1:DEPTH];
    logic [4:0]       dst_q   [1:DEPTH];
    logic [4:0]       dst_d   [1:DEPTH];
    logic [AW-1:0]    avail_q [1:DEPTH];
    logic [AW-1:0]    avail_d [1:DEPTH];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;
    logic [NREAD-1:0] stall_req;

    // Youngest writer wins: scan from the oldest slot so the smallest matching k survives.
    always_comb begin
        logic [4:0]    r;
        logic [AW-1:0] hit;
        fwd_data  = '0;
        fwd_src   = '0;
        stall_req = '0;
        r         = '0;
        hit       = '0;
        for (int p = 0; p < NREAD; p++) begin
            r   = rd_reg[5*p +: 5];
            hit = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (v_q[k] && (dst_q[k] == r)) begin
                    hit = AW'(k);
                end
            end
            fwd_data[W*p +: W] = rd_data[W*p +: W];
            if ((r != 5'd0) && (hit != '0)) begin
                fwd_src[AW*p +: AW] = hit;
                fwd_data[W*p +: W]  = stage_data[W*(int'(hit)-1) +: W];
                if (hit < avail_q[hit]) begin
                    stall_req[p] = 1'b1;
                end
            end
        end
    end

    assign stall = issue_valid && !flush && (|stall_req);

    always_comb begin
        v_d[1]     = 1'b0;
        dst_d[1]   = issue_dst;
        avail_d[1] = issue_avail;
        if (issue_avail == '0) begin
            avail_d[1] = AW'(1);
        end else if (issue_avail > AW'(DEPTH)) begin
            avail_d[1] = AW'(DEPTH);
        end
        if (issue_valid && !flush && !stall && (issue_dst != 5'd0)) begin
            v_d[1] = 1'b1;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            v_d[k]     = v_q[k-1];
            dst_d[k]   = dst_q[k-1];
            avail_d[k] = avail_q[k-1];
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // The back end never stalls, so the slots shift every cycle; stalls only insert bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                v_q[k]     <= 1'b0;
                dst_q[k]   <= '0;
                avail_q[k] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                v_q[k]     <= v_d[k];
                dst_q[k]   <= dst_d[k];
                avail_q[k] <= avail_d[k];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scoreboard bench for fwd_scoreboard (NREAD=2, DEPTH=3): expectations are queued
// as each ID cycle is driven and popped when the combinational outputs settle.
module tb_fwd_scoreboard;

    localparam int NREAD = 2;
    localparam int DEPTH = 3;
    localparam int W     = 32;
    localparam int AW    = 2;
    localparam int CNT_W = 16;

    localparam logic [W-1:0] SLOT1 = 32'h0040_0008;
    localparam logic [W-1:0] SLOT2 = 32'hDEAD_BEEF;
    localparam logic [W-1:0] SLOT3 = 32'hC0FF_EE03;

    logic                clk = 1'b0;
    logic                reset;
    logic                issue_valid;
    logic [4:0]          issue_dst;
    logic [AW-1:0]       issue_avail;
    logic                flush;
    logic [NREAD*5-1:0]  rd_reg;
    logic [NREAD*W-1:0]  rd_data;
    logic [DEPTH*W-1:0]  stage_data;
    logic [NREAD*W-1:0]  fwd_data;
    logic [NREAD*AW-1:0] fwd_src;
    logic                stall;
    logic [CNT_W-1:0]    stall_count;

    typedef struct {
        logic             stall;
        logic [AW-1:0]    src0;
        logic [AW-1:0]    src1;
        logic [W-1:0]     d0;
        logic [W-1:0]     d1;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    fwd_scoreboard #(
        .NREAD(NREAD), .DEPTH(DEPTH), .W(W), .AW(AW), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_avail (issue_avail),
        .flush       (flush),
        .rd_reg      (rd_reg),
        .rd_data     (rd_data),
        .stage_data  (stage_data),
        .fwd_data    (fwd_data),
        .fwd_src     (fwd_src),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rf_val(input int port, input logic [4:0] r);
        return (port == 0 ? 32'hAAAA_0000 : 32'hBBBB_0000) | {27'd0, r};
    endfunction

    function automatic logic [W-1:0] exp_data(input int port, input logic [4:0] r,
                                               input logic [AW-1:0] src);
        case (src)
            2'd1:    return SLOT1;
            2'd2:    return SLOT2;
            2'd3:    return SLOT3;
            default: return rf_val(port, r);
        endcase
    endfunction

    // One ID cycle: drive inputs just after the rising edge and queue what must come out.
    task automatic applyStimulus(input string tag, input logic rn, input logic iv,
                                 input logic [4:0] dst, input logic [AW-1:0] av,
                                 input logic fl, input logic [4:0] r0, input logic [4:0] r1,
                                 input logic es, input logic [AW-1:0] s0,
                                 input logic [AW-1:0] s1, input logic [CNT_W-1:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rn;
        issue_valid = iv;
        issue_dst   = dst;
        issue_avail = av;
        flush       = fl;
        rd_reg      = {r1, r0};
        rd_data     = {rf_val(1, r1), rf_val(0, r0)};
        e.stall = es;
        e.src0  = s0;
        e.src1  = s1;
        e.d0    = exp_data(0, r0, s0);
        e.d1    = exp_data(1, r1, s1);
        e.cnt   = ec;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        @(negedge clk);
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_checks++;
        assert (stall === e.stall) else begin
            n_fail++;
            $error("[TB] FAIL %s stall: got %b want %b", tag, stall, e.stall);
        end
        n_checks++;
        assert (fwd_src[1:0] === e.src0) else begin
            n_fail++;
            $error("[TB] FAIL %s src0: got %0d want %0d", tag, fwd_src[1:0], e.src0);
        end
        n_checks++;
        assert (fwd_src[3:2] === e.src1) else begin
            n_fail++;
            $error("[TB] FAIL %s src1: got %0d want %0d", tag, fwd_src[3:2], e.src1);
        end
        n_checks++;
        assert (fwd_data[31:0] === e.d0) else begin
            n_fail++;
            $error("[TB] FAIL %s data0: got %h want %h", tag, fwd_data[31:0], e.d0);
        end
        n_checks++;
        assert (fwd_data[63:32] === e.d1) else begin
            n_fail++;
            $error("[TB] FAIL %s data1: got %h want %h", tag, fwd_data[63:32], e.d1);
        end
        n_checks++;
        assert (stall_count === e.cnt) else begin
            n_fail++;
            $error("[TB] FAIL %s count: got %0d want %0d", tag, stall_count, e.cnt);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic iv,
                        input logic [4:0] dst, input logic [AW-1:0] av, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1, input logic es,
                        input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [CNT_W-1:0] ec);
        applyStimulus(tag, rn, iv, dst, av, fl, r0, r1, es, s0, s1, ec);
        checkOutput();
    endtask

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_dst   = '0;
        issue_avail = '0;
        flush       = 1'b0;
        rd_reg      = '0;
        rd_data     = '0;
        stage_data  = {SLOT3, SLOT2, SLOT1};
        repeat (3) @(posedge clk);

        //   tag           rn iv dst av fl r0  r1  stall s0 s1 cnt
        step("reset_state", 1, 0, 0,  0, 0, 0,  0,  0,    0, 0, 0);
        step("t1_issue",    1, 1, 8,  2, 0, 0,  0,  0,    0, 0, 0);
        step("t1_stall",    1, 1, 0,  0, 0, 8,  0,  1,    1, 0, 0);
        step("t1_fwd",      1, 1, 0,  0, 0, 8,  0,  0,    2, 0, 1);
        step("t2_issue",    1, 1, 9,  3, 0, 0,  0,  0,    0, 0, 1);
        step("t2_stall_a",  1, 1, 0,  0, 0, 0,  9,  1,    0, 1, 1);
        step("t2_stall_b",  1, 1, 0,  0, 0, 0,  9,  1,    0, 2, 2);
        step("t2_fwd",      1, 1, 0,  0, 0, 0,  9,  0,    0, 3, 3);
        step("t3_issue",    1, 1, 31, 1, 0, 0,  0,  0,    0, 0, 3);
        step("t3_fwd",      1, 1, 0,  0, 0, 31, 0,  0,    1, 0, 3);
        step("t4_alu",      1, 1, 5,  2, 0, 0,  0,  0,    0, 0, 3);
        step("t4_jal",      1, 1, 5,  1, 0, 0,  0,  0,    0, 0, 3);
        step("t4_young",    1, 1, 0,  0, 0, 5,  5,  0,    1, 1, 3);
        step("t4_next",     1, 1, 0,  0, 0, 5,  5,  0,    2, 2, 3);
        step("t5_zero_wr",  1, 1, 0,  2, 0, 0,  0,  0,    0, 0, 3);
        step("t5_read0",    1, 1, 0,  0, 0, 0,  0,  0,    0, 0, 3);
        step("t6_issue",    1, 1, 12, 3, 0, 0,  0,  0,    0, 0, 3);
        step("t6_flush",    1, 1, 0,  0, 1, 12, 0,  0,    1, 0, 3);
        step("t6_stall",    1, 1, 0,  0, 0, 12, 0,  1,    2, 0, 3);
        step("t6_issue2",   1, 1, 13, 3, 0, 0,  0,  0,    0, 0, 4);
        step("t6_rst",      0, 1, 0,  0, 0, 0,  13, 1,    0, 1, 4);
        step("t6_after",    1, 1, 0,  0, 0, 12, 13, 0,    0, 0, 0);
        step("t7_clamp",    1, 1, 7,  0, 0, 0,  0,  0,    0, 0, 0);
        step("t7_self",     1, 1, 7,  2, 0, 7,  0,  0,    1, 0, 0);
        step("t7_stall",    1, 1, 0,  0, 0, 7,  0,  1,    1, 0, 0);
        step("t7_fwd",      1, 1, 0,  0, 0, 7,  0,  0,    2, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
